sigma_delta_dac_mc: RTL and testbench

- Parametrised multi-channel first-order sigma-delta audio DAC. Generalises the fixed two-pin AUDIO_L/AUDIO_R path to N channels of configurable width.
- Sits between the guest core's audio mixer and the board's 1-bit audio pins.
- Adds per-channel slew limiting, so reset, mute and large sample steps produce no pops.
- Adds signed/unsigned input mode and a mute control.

---
 rtl/sigma_delta_dac_mc.sv | 90 +++++++++
 tb/tb_sigma_delta_dac_mc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel first-order sigma-delta DAC with per-channel slew limiting and mute.
// Latency: din_valid at edge n -> hold at n, level moves at n+1, dac_out reflects it from n+2.
// Backpressure: none; din_valid is accepted on every cycle it is asserted.
module sigma_delta_dac_mc #(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 2,
  parameter int SIGNED     = 1,
  parameter int SLEW_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      din_valid,
  input  logic                      mute,
  output logic [CHANNELS-1:0]       dac_out,
  output logic                      ramp_busy
);

  // Midscale is the silent level; the soft start and mute both aim here.
  localparam logic [WIDTH-1:0] MID  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] STEP = WIDTH'(1 << SLEW_SHIFT);

  logic [CHANNELS-1:0] w_mismatch;
  logic [CHANNELS-1:0] w_dac;
  logic                r_ramp_busy;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] w_sample;
    logic [WIDTH-1:0] w_u;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_diff;
    logic             w_up;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_acc;
    logic             r_out;

    assign w_sample = din[k*WIDTH +: WIDTH];

    // Two's complement maps onto offset binary by flipping the sign bit.
    if (SIGNED != 0) begin : g_signed
      assign w_u = {~w_sample[WIDTH-1], w_sample[WIDTH-2:0]};
    end else begin : g_unsigned
      assign w_u = w_sample;
    end

    assign w_target      = mute ? MID : r_hold;
    assign w_up          = w_target > r_level;
    assign w_diff        = w_up ? (w_target - r_level) : (r_level - w_target);
    assign w_sum         = {1'b0, r_acc} + {1'b0, r_level};
    assign w_mismatch[k] = (w_target != r_level);
    assign w_dac[k]      = r_out;

    // Capture the latest sample; mute does not block capture so unmuting lands on fresh data.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       r_hold <= MID;
      else if (din_valid) r_hold <= w_u;
    end

    // Slew limiter: move toward the target by at most STEP per clock, never overshooting.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)           r_level <= '0;
      else if (w_diff <= STEP) r_level <= w_target;
      else if (w_up)           r_level <= r_level + STEP;
      else                     r_level <= r_level - STEP;
    end

    // First-order modulator: the carry out of the accumulator is the 1-bit output.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_acc <= '0;
        r_out <= 1'b0;
      end else begin
        r_acc <= w_sum[WIDTH-1:0];
        r_out <= w_sum[WIDTH];
      end
    end
  end

  // Busy flag reflects whether any channel was still off target at this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ramp_busy <= 1'b0;
    else          r_ramp_busy <= |w_mismatch;
  end

  assign dac_out   = w_dac;
  assign ramp_busy = r_ramp_busy;

endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
// Bench for sigma_delta_dac_mc: a 4-bit unsigned two-channel instance against a
// reference model and vector table, plus a 16-bit signed instance for the coarse-step case.
module tb_sigma_delta_dac_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  a_din;
  logic        a_dv, a_mute;
  logic [1:0]  a_out;
  logic        a_busy;
  logic [31:0] b_din;
  logic        b_dv, b_mute;
  logic [1:0]  b_out;
  logic        b_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sigma_delta_dac_mc #(.WIDTH(4), .CHANNELS(2), .SIGNED(0), .SLEW_SHIFT(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .din(a_din), .din_valid(a_dv), .mute(a_mute),
    .dac_out(a_out), .ramp_busy(a_busy));

  sigma_delta_dac_mc #(.WIDTH(16), .CHANNELS(2), .SIGNED(1), .SLEW_SHIFT(12)) dut_b (
    .clk(clk), .reset_n(reset_n), .din(b_din), .din_valid(b_dv), .mute(b_mute),
    .dac_out(b_out), .ramp_busy(b_busy));

  // Reference model of the 4-bit instance: plain integer arithmetic on the documented rules.
  int       m_hold[2];
  int       m_level[2];
  int       m_acc[2];
  logic [1:0] m_out;
  logic     m_busy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_hold[k] = 8; m_level[k] = 0; m_acc[k] = 0;
      end
      m_out  = 2'b00;
      m_busy = 1'b0;
    end else begin
      int   tgt;
      int   sum;
      logic busy;
      busy = 1'b0;
      for (int k = 0; k < 2; k++) begin
        tgt = a_mute ? 8 : m_hold[k];
        if (m_level[k] != tgt) busy = 1'b1;
        sum = m_acc[k] + m_level[k];
        m_out[k] = (sum >= 16);
        m_acc[k] = sum % 16;
        if (tgt - m_level[k] <= 1 && m_level[k] - tgt <= 1) m_level[k] = tgt;
        else if (tgt > m_level[k])                          m_level[k] = m_level[k] + 1;
        else                                                m_level[k] = m_level[k] - 1;
      end
      m_busy = busy;
      if (a_dv) begin
        m_hold[0] = int'(a_din[3:0]);
        m_hold[1] = int'(a_din[7:4]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Advance one edge, then compare the 4-bit instance against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("model_out",  32'(a_out),  32'(m_out));
    chk("model_busy", 32'(a_busy), 32'(m_busy));
    chk("model_lvl0", 32'(dut_a.g_ch[0].r_level), 32'(m_level[0]));
    chk("model_lvl1", 32'(dut_a.g_ch[1].r_level), 32'(m_level[1]));
  endtask

  typedef struct {
    logic       dv;
    logic [7:0] din;
    logic       mute;
    int         lvl0;
    int         lvl1;
    logic       busy;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int ones0, ones1;
    // Soft start, settle, then ch0 -> 0 and ch1 -> 15 from a single strobe.
    for (int i = 1; i <= 8; i++) tbl[i-1] = '{1'b0, 8'h00, 1'b0, i, i, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 8, 8, 1'b0};
    tbl[9] = '{1'b1, 8'hF0, 1'b0, 8, 8, 1'b0};
    for (int j = 1; j <= 7; j++) tbl[9+j] = '{1'b0, 8'h00, 1'b0, 8-j, 8+j, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 0, 15, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 0, 15, 1'b0};

    reset_n = 1'b0;
    a_din = 8'h00; a_dv = 1'b0; a_mute = 1'b0;
    b_din = 32'h0; b_dv = 1'b0; b_mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",   32'(a_out),  32'd0);
    chk("rst_busy",  32'(a_busy), 32'd0);
    chk("rst_lvl0",  32'(dut_a.g_ch[0].r_level), 32'd0);
    chk("rst_hold0", 32'(dut_a.g_ch[0].r_hold),  32'd8);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      if (i == 9) begin
        ones0 = 0; ones1 = 0;
        repeat (16) begin
          tick();
          ones0 += int'(a_out[0]);
          ones1 += int'(a_out[1]);
        end
        chk("density_mid_ch0", 32'(ones0), 32'd8);
        chk("density_mid_ch1", 32'(ones1), 32'd8);
      end
      a_dv = tbl[i].dv; a_din = tbl[i].din; a_mute = tbl[i].mute;
      tick();
      a_dv = 1'b0;
      chk($sformatf("tbl%0d_lvl0", i), 32'(dut_a.g_ch[0].r_level), 32'(tbl[i].lvl0));
      chk($sformatf("tbl%0d_lvl1", i), 32'(dut_a.g_ch[1].r_level), 32'(tbl[i].lvl1));
      chk($sformatf("tbl%0d_busy", i), 32'(a_busy), 32'(tbl[i].busy));
    end

    ones0 = 0; ones1 = 0;
    repeat (16) begin
      tick();
      ones0 += int'(a_out[0]);
      ones1 += int'(a_out[1]);
    end
    chk("density_zero_ch0", 32'(ones0), 32'd0);
    chk("density_full_ch1", 32'(ones1), 32'd15);

    // Signed 16-bit: most negative sample slews MID -> 0 in 8 coarse steps.
    b_dv = 1'b1; b_din = {16'h0000, 16'h8000};
    tick();
    b_dv = 1'b0;
    chk("b_hold0", 32'(dut_b.g_ch[0].r_hold), 32'h0000);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("b_lvl0_step%0d", i), 32'(dut_b.g_ch[0].r_level), 32'h8000 - 32'(i) * 32'h1000);
    end
    ones0 = 0;
    repeat (16) begin
      tick();
      ones0 += int'(b_out[0]);
    end
    chk("b_density_ch0", 32'(ones0), 32'd0);
    chk("b_lvl1", 32'(dut_b.g_ch[1].r_level), 32'h8000);
    chk("b_busy_idle", 32'(b_busy), 32'd0);

    // Mute: ch0 settled at 15, muting slews to MID; capture while muted does not move level.
    a_dv = 1'b1; a_din = 8'hFF;
    tick();
    a_dv = 1'b0;
    repeat (15) tick();
    chk("mute_pre_lvl0", 32'(dut_a.g_ch[0].r_level), 32'd15);
    a_mute = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("mute_lvl0_%0d", i), 32'(dut_a.g_ch[0].r_level), 32'(15 - i));
    end
    a_dv = 1'b1; a_din = 8'hF2;
    tick();
    a_dv = 1'b0;
    chk("mute_hold0", 32'(dut_a.g_ch[0].r_hold), 32'd2);
    repeat (3) tick();
    chk("mute_lvl0_held", 32'(dut_a.g_ch[0].r_level), 32'd8);
    a_mute = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("unmute_lvl0_%0d", i), 32'(dut_a.g_ch[0].r_level), 32'(8 - i));
    end

    // Mid-ramp retarget: heading to 15, redirect to 9 while at 11.
    a_dv = 1'b1; a_din = 8'hF8;
    tick();
    a_dv = 1'b0;
    repeat (6) tick();
    chk("retgt_start", 32'(dut_a.g_ch[0].r_level), 32'd8);
    a_dv = 1'b1; a_din = 8'hFF;
    tick();
    a_dv = 1'b0;
    tick();
    tick();
    a_dv = 1'b1; a_din = 8'hF9;
    tick();
    a_dv = 1'b0;
    chk("retgt_lvl11", 32'(dut_a.g_ch[0].r_level), 32'd11);
    tick();
    chk("retgt_lvl10", 32'(dut_a.g_ch[0].r_level), 32'd10);
    tick();
    chk("retgt_lvl9", 32'(dut_a.g_ch[0].r_level), 32'd9);
    repeat (3) tick();
    chk("retgt_hold9", 32'(dut_a.g_ch[0].r_level), 32'd9);

    // Asynchronous reset mid-ramp at level 12.
    a_dv = 1'b1; a_din = 8'hFF;
    tick();
    a_dv = 1'b0;
    repeat (3) tick();
    chk("arst_pre_lvl0", 32'(dut_a.g_ch[0].r_level), 32'd12);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out",  32'(a_out),  32'd0);
    chk("arst_busy", 32'(a_busy), 32'd0);
    chk("arst_lvl0", 32'(dut_a.g_ch[0].r_level), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("arst_ramp_%0d", i), 32'(dut_a.g_ch[0].r_level), 32'(i));
    end

    // Randomised traffic against the model, with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      a_dv  = ($urandom_range(0, 3) == 0);
      a_din = 8'($urandom);
      if ($urandom_range(0, 15) == 0) a_mute = ~a_mute;
      if ($urandom_range(0, 99) == 0) begin
        #2;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
